// File: rtl/rr_stream_pkg.sv
// Shared types and helpers for the round-robin stream multiplexer.
package rr_stream_pkg;

    localparam int unsigned N_CH = 4;

    typedef logic [1:0] ch_idx_t;

    function automatic ch_idx_t next_idx(input ch_idx_t idx);
        return idx + ch_idx_t'(1);
    endfunction

endpackage

// File: rtl/rr_pick_4.sv
// Combinational rotating-priority picker: first requester at or after i_ptr wins.
module rr_pick_4
    import rr_stream_pkg::*;
(
    input  logic [N_CH-1:0] i_req,
    input  ch_idx_t         i_ptr,
    output logic            o_gnt_valid,
    output ch_idx_t         o_gnt_idx,
    output logic [N_CH-1:0] o_gnt_onehot
);

    logic    w_found;
    ch_idx_t w_idx;
    ch_idx_t w_cand;

    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_cand  = '0;
        for (int k = 0; k < int'(N_CH); k++) begin
            w_cand = i_ptr + ch_idx_t'(k);
            if (!w_found && i_req[w_cand]) begin
                w_found = 1'b1;
                w_idx   = w_cand;
            end
        end
    end

    always_comb begin
        o_gnt_onehot = '0;
        if (w_found) begin
            o_gnt_onehot[w_idx] = 1'b1;
        end
    end

    assign o_gnt_valid = w_found;
    assign o_gnt_idx   = w_idx;

endmodule

// File: rtl/rr_stream_mux_4_1.sv
// Four-channel round-robin valid/ready multiplexer with a single registered output stage.
module rr_stream_mux_4_1
    import rr_stream_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_CH-1:0]  i_in_valid,
    output logic [N_CH-1:0]  o_in_ready,
    input  logic [WIDTH-1:0] i_d0,
    input  logic [WIDTH-1:0] i_d1,
    input  logic [WIDTH-1:0] i_d2,
    input  logic [WIDTH-1:0] i_d3,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out_data,
    output ch_idx_t          o_out_sel
);

    ch_idx_t          r_ptr;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    ch_idx_t          r_out_sel;

    logic             w_load;
    logic             w_gnt_valid;
    ch_idx_t          w_gnt_idx;
    logic [N_CH-1:0]  w_gnt_onehot;
    logic [WIDTH-1:0] w_sel_data;

    rr_pick_4 u_pick (
        .i_req        (i_in_valid),
        .i_ptr        (r_ptr),
        .o_gnt_valid  (w_gnt_valid),
        .o_gnt_idx    (w_gnt_idx),
        .o_gnt_onehot (w_gnt_onehot)
    );

    // Register is free when empty or being drained this cycle.
    assign w_load     = !r_out_valid || i_out_ready;
    assign o_in_ready = w_gnt_onehot & {N_CH{w_load}};

    always_comb begin
        if (w_gnt_idx == 2'd0) begin
            w_sel_data = i_d0;
        end else if (w_gnt_idx == 2'd1) begin
            w_sel_data = i_d1;
        end else if (w_gnt_idx == 2'd2) begin
            w_sel_data = i_d2;
        end else begin
            w_sel_data = i_d3;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
        end else if (w_load) begin
            if (w_gnt_valid) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_sel_data;
                r_out_sel   <= w_gnt_idx;
                r_ptr       <= next_idx(w_gnt_idx);
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_sel   = r_out_sel;

endmodule

// File: tb/tb_rr_stream_mux_4_1.sv
// Directed self-checking bench for rr_stream_mux_4_1.
module tb_rr_stream_mux_4_1;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic [W-1:0] d0, d1, d2, d3;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   out_sel;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rr_stream_mux_4_1 #(.WIDTH(W)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_d0        (d0),
        .i_d1        (d1),
        .i_d2        (d2),
        .i_d3        (d3),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_data  (out_data),
        .o_out_sel   (out_sel)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [1:0] s,
                             input logic [W-1:0] d);
        check({tag, "_valid"}, 32'(out_valid), 32'(v));
        check({tag, "_sel"}, 32'(out_sel), 32'(s));
        check({tag, "_data"}, 32'(out_data), 32'(d));
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 4'b0000;
        out_ready = 1'b0;
        d0 = 4'h1; d1 = 4'h2; d2 = 4'h3; d3 = 4'h4;
        tick();
        tick();
        check_out("reset", 1'b0, 2'd0, 4'h0);
        check("reset_in_ready", 32'(in_ready), 32'h0);
        rst = 1'b0;
        tick();
        check("idle_valid", 32'(out_valid), 32'h0);

        // All channels valid: grants rotate 0,1,2,3,0 at one word per cycle.
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        #1;
        check("all_first_ready", 32'(in_ready), 32'h1);
        for (int k = 0; k < 5; k++) begin
            tick();
            check_out($sformatf("all_%0d", k), 1'b1, 2'(k % 4), 4'(k % 4 + 1));
            check($sformatf("all_ready_%0d", k), 32'(in_ready), 32'(1) << ((k + 1) % 4));
        end

        // Empty inputs: output drains, ptr (now 1) holds.
        in_valid = 4'b0000;
        #1;
        check("empty_ready", 32'(in_ready), 32'h0);
        tick();
        check_out("empty", 1'b0, 2'd0, 4'h1);
        in_valid = 4'b1111;
        #1;
        check("ptr_hold_ready", 32'(in_ready), 32'h2);

        // Backpressure with a full register.
        tick();
        check_out("bp_load", 1'b1, 2'd1, 4'h2);
        out_ready = 1'b0;
        #1;
        check("bp_ready0", 32'(in_ready), 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_out($sformatf("bp_hold_%0d", k), 1'b1, 2'd1, 4'h2);
            check($sformatf("bp_ready_%0d", k), 32'(in_ready), 32'h0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'h4);
        tick();
        check_out("bp_refill", 1'b1, 2'd2, 4'h3);

        // Single requester, then ptr=3 with channels 0 and 2 valid.
        in_valid = 4'b0100;
        d2       = 4'hA;
        #1;
        check("single_ready", 32'(in_ready), 32'h4);
        tick();
        check_out("single", 1'b1, 2'd2, 4'hA);
        in_valid = 4'b0101;
        #1;
        check("wrap_ready", 32'(in_ready), 32'h1);
        tick();
        check_out("wrap", 1'b1, 2'd0, 4'h1);

        // Asynchronous reset mid-cycle with a held word.
        out_ready = 1'b0;
        in_valid  = 4'b1111;
        tick();
        check_out("pre_rst", 1'b1, 2'd0, 4'h1);
        #2;
        rst = 1'b1;
        #1;
        check_out("async_rst", 1'b0, 2'd0, 4'h0);
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_ready", 32'(in_ready), 32'h1);
        out_ready = 1'b1;
        tick();
        check_out("post_rst", 1'b1, 2'd0, 4'h1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
